// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared definitions for the multi-cycle divider: bus widths,
//               state encodings, handshake levels and a conditional
//               absolute-value helper.
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

  localparam int REG_BUS        = 32;
  localparam int DOUBLE_REG_BUS = 64;

  // Divider state encodings
  localparam logic [1:0] c_DIV_FREE    = 2'b00;
  localparam logic [1:0] c_DIV_BY_ZERO = 2'b01;
  localparam logic [1:0] c_DIV_ON      = 2'b10;
  localparam logic [1:0] c_DIV_END     = 2'b11;

  // Handshake levels
  localparam logic c_DIV_START            = 1'b1;
  localparam logic c_DIV_STOP             = 1'b0;
  localparam logic c_DIV_RESULT_READY     = 1'b1;
  localparam logic c_DIV_RESULT_NOT_READY = 1'b0;
  localparam logic c_RST_ENABLE           = 1'b1;

  // Two's-complement magnitude, applied only to signed negative operands.
  function automatic logic [REG_BUS-1:0] abs_if(input logic [REG_BUS-1:0] v,
                                                input logic              is_signed);
    return (is_signed && v[REG_BUS-1]) ? (~v + {{(REG_BUS-1){1'b0}}, 1'b1}) : v;
  endfunction

endpackage : div_pkg
`default_nettype wire

// File: rtl/div.sv
`default_nettype none
// ============================================================================
// Module      : div
// Description : 32-bit radix-2 restoring divider, one quotient bit per clock.
//               Returns {remainder, quotient}; signed mode truncates toward
//               zero and the remainder follows the sign of the dividend.
// Ports       : clk          - system clock, rising edge
//               rst          - synchronous active-high reset
//               signed_div_i - 1 = signed divide, 0 = unsigned
//               opdata1_i    - dividend (sampled at acceptance only)
//               opdata2_i    - divisor  (sampled at acceptance only)
//               start_i      - request, held until ready_o is seen
//               annul_i      - cancel: blocks acceptance / aborts in flight
//               result_o     - {remainder, quotient}, registered
//               ready_o      - result valid flag, registered
// Revision    : 1.0 - initial release
// ============================================================================
module div
  import div_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      signed_div_i,
  input  logic [REG_BUS-1:0]        opdata1_i,
  input  logic [REG_BUS-1:0]        opdata2_i,
  input  logic                      start_i,
  input  logic                      annul_i,
  output logic [DOUBLE_REG_BUS-1:0] result_o,
  output logic                      ready_o
);

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic [5:0]         r_cnt;
  // Holds the dividend magnitude; bits shift out of the top as quotient
  // bits shift in at the bottom, so after 32 steps it holds the quotient.
  logic [REG_BUS-1:0] r_dq;
  logic [REG_BUS-1:0] r_divisor;
  logic [REG_BUS-1:0] r_rem;
  logic               r_signed;
  logic               r_neg1;
  logic               r_neg2;

  logic               w_accept;
  logic               w_div_zero;
  logic               w_last;
  logic [REG_BUS:0]   w_partial;
  logic [REG_BUS+1:0] w_trial;
  logic               w_qbit;
  logic [REG_BUS-1:0] w_rem_next;
  logic [REG_BUS-1:0] w_quo_next;
  logic [REG_BUS-1:0] w_quo_fix;
  logic [REG_BUS-1:0] w_rem_fix;

  assign w_accept   = (start_i == c_DIV_START) && !annul_i;
  assign w_div_zero = (opdata2_i == '0);
  assign w_last     = (r_cnt == 6'd31);

  // One restoring step. The partial remainder can reach 2*divisor-1, so it
  // needs 33 bits; one extra guard bit on the subtract exposes the borrow.
  assign w_partial  = {r_rem, r_dq[REG_BUS-1]};
  assign w_trial    = {1'b0, w_partial} - {2'b00, r_divisor};
  assign w_qbit     = ~w_trial[REG_BUS+1];
  // Either choice is below the divisor, so it always fits in 32 bits.
  assign w_rem_next = w_qbit ? w_trial[REG_BUS-1:0] : w_partial[REG_BUS-1:0];
  assign w_quo_next = {r_dq[REG_BUS-2:0], w_qbit};

  // Sign fix-up; 0x80000000 / -1 naturally wraps back to 0x80000000.
  assign w_quo_fix  = (r_signed && (r_neg1 ^ r_neg2)) ? (~w_quo_next + 32'd1) : w_quo_next;
  assign w_rem_fix  = (r_signed && r_neg1)            ? (~w_rem_next + 32'd1) : w_rem_next;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst == c_RST_ENABLE) begin
      r_state <= c_DIV_FREE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_DIV_FREE: begin
        if (w_accept) begin
          w_next_state = w_div_zero ? c_DIV_BY_ZERO : c_DIV_ON;
        end
      end
      c_DIV_BY_ZERO: begin
        w_next_state = annul_i ? c_DIV_FREE : c_DIV_END;
      end
      c_DIV_ON: begin
        if (annul_i) begin
          w_next_state = c_DIV_FREE;
        end else if (w_last) begin
          w_next_state = c_DIV_END;
        end
      end
      c_DIV_END: begin
        // annul_i is deliberately ignored once the result is available.
        if (start_i == c_DIV_STOP) begin
          w_next_state = c_DIV_FREE;
        end
      end
      default: w_next_state = c_DIV_FREE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst == c_RST_ENABLE) begin
      r_cnt     <= '0;
      r_dq      <= '0;
      r_divisor <= '0;
      r_rem     <= '0;
      r_signed  <= 1'b0;
      r_neg1    <= 1'b0;
      r_neg2    <= 1'b0;
      result_o  <= '0;
      ready_o   <= c_DIV_RESULT_NOT_READY;
    end else begin
      case (r_state)
        c_DIV_FREE: begin
          if (w_accept && !w_div_zero) begin
            r_dq      <= abs_if(opdata1_i, signed_div_i);
            r_divisor <= abs_if(opdata2_i, signed_div_i);
            r_rem     <= '0;
            r_cnt     <= '0;
            r_signed  <= signed_div_i;
            r_neg1    <= signed_div_i & opdata1_i[REG_BUS-1];
            r_neg2    <= signed_div_i & opdata2_i[REG_BUS-1];
          end
        end
        c_DIV_BY_ZERO: begin
          if (!annul_i) begin
            result_o <= '0;
            ready_o  <= c_DIV_RESULT_READY;
          end
        end
        c_DIV_ON: begin
          if (annul_i) begin
            r_cnt   <= '0;
            ready_o <= c_DIV_RESULT_NOT_READY;
          end else begin
            r_rem <= w_rem_next;
            r_dq  <= w_quo_next;
            r_cnt <= r_cnt + 6'd1;
            if (w_last) begin
              result_o <= {w_rem_fix, w_quo_fix};
              ready_o  <= c_DIV_RESULT_READY;
            end
          end
        end
        c_DIV_END: begin
          if (start_i == c_DIV_STOP) begin
            result_o <= '0;
            ready_o  <= c_DIV_RESULT_NOT_READY;
          end
        end
        default: begin
          ready_o <= c_DIV_RESULT_NOT_READY;
        end
      endcase
    end
  end

endmodule : div
`default_nettype wire
